// File: rtl/gray_scale_controller_pkg.sv
// Shared types and defaults for the gray-scale read/write address controller.
// Frame geometry defaults match the 5x5 reference image used with the data path.
package gray_scale_controller_pkg;

    localparam int DEFAULT_IMAGE_HEIGHT    = 5;
    localparam int DEFAULT_IMAGE_WIDTH     = 5;
    localparam int DEFAULT_ADRR_WIDTH_BRAM = 6;
    localparam int DEFAULT_PIPE_LATENCY    = 3;
    localparam int FRAME_COUNT_WIDTH       = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int frame_pixels(input int height, input int width);
        return height * width;
    endfunction

endpackage

// File: rtl/gray_scale_controller_addr_delay_line.sv
// Synchronous-reset shift register that delays {valid, address} to line up
// with the output of the gray calculation pipeline.
module addr_delay_line #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] shift_data,
    output logic [WIDTH-1:0] delayed_data
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= shift_data;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign delayed_data = stages[DEPTH-1];

endmodule

// File: rtl/gray_scale_controller.sv
// Frame controller for the RGB-to-gray data path: issues read addresses with
// valid_in, produces pipeline-aligned gray write addresses and reports frame completion.
module gray_scale_controller
    import gray_scale_controller_pkg::*;
#(
    parameter int IMAGE_HEIGHT    = DEFAULT_IMAGE_HEIGHT,
    parameter int IMAGE_WIDTH     = DEFAULT_IMAGE_WIDTH,
    parameter int ADRR_WIDTH_BRAM = DEFAULT_ADRR_WIDTH_BRAM,
    parameter int PIPE_LATENCY    = DEFAULT_PIPE_LATENCY
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         valid_in,
    output logic [ADRR_WIDTH_BRAM-1:0]   addr0_bram_read,
    output logic [ADRR_WIDTH_BRAM-1:0]   addr0_bram_write,
    output logic                         write_strobe,
    output logic                         busy,
    output logic                         done,
    output logic [FRAME_COUNT_WIDTH-1:0] frame_count
);

    localparam int N = frame_pixels(IMAGE_HEIGHT, IMAGE_WIDTH);
    localparam logic [ADRR_WIDTH_BRAM-1:0] LAST_PIXEL = ADRR_WIDTH_BRAM'(N - 1);

    generate
        if (N > 2 ** ADRR_WIDTH_BRAM) begin : g_bad_addr_width
            $error("IMAGE_HEIGHT*IMAGE_WIDTH does not fit in ADRR_WIDTH_BRAM bits");
        end
        if (PIPE_LATENCY < 1) begin : g_bad_latency
            $error("PIPE_LATENCY must be at least 1");
        end
    endgenerate

    state_t                         state;
    state_t                         state_next;
    logic [ADRR_WIDTH_BRAM-1:0]     rd_cnt;
    logic [FRAME_COUNT_WIDTH-1:0]   frame_cnt;
    logic [ADRR_WIDTH_BRAM:0]       delay_head;
    logic [ADRR_WIDTH_BRAM:0]       delay_tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Drain ends on the delayed strobe of the last pixel, so it tracks PIPE_LATENCY
    // without a separate drain counter.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = READ;
            READ:    if (rd_cnt == LAST_PIXEL) state_next = DRAIN;
            DRAIN:   if (write_strobe && addr0_bram_write == LAST_PIXEL) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt    <= '0;
            frame_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                rd_cnt <= '0;
            end else if (state == READ && rd_cnt != LAST_PIXEL) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (state == DONE) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign valid_in        = (state == READ);
    assign busy            = (state != IDLE);
    assign done            = (state == DONE);
    assign addr0_bram_read = rd_cnt;
    assign frame_count     = frame_cnt;
    assign delay_head      = {valid_in, rd_cnt};

    addr_delay_line #(
        .DEPTH (PIPE_LATENCY),
        .WIDTH (ADRR_WIDTH_BRAM + 1)
    ) u_addr_delay_line (
        .clk          (clk),
        .rst          (rst),
        .shift_data   (delay_head),
        .delayed_data (delay_tail)
    );

    // Read address holds between frames, so the delayed address also holds while strobe is low.
    assign {write_strobe, addr0_bram_write} = delay_tail;

endmodule

// File: doc/gray_scale_controller.md
# gray_scale_controller

Control stage directly upstream of the RGB-to-gray data path. It drives the data path's read-side handshake (`valid_in` and the port-A read address of the RGB BRAM), generates the gray BRAM write address aligned to the calculation pipeline's output, and reports frame completion. One `start` pulse converts one full IMAGE_HEIGHT × IMAGE_WIDTH frame.

## Interface
Parameters:
- IMAGE_HEIGHT, 5, frame rows
- IMAGE_WIDTH, 5, frame columns
- ADRR_WIDTH_BRAM, 6, BRAM address width; IMAGE_HEIGHT*IMAGE_WIDTH ≤ 2^ADRR_WIDTH_BRAM (elaboration error otherwise)
- PIPE_LATENCY, 3, cycles from `valid_in` asserted to the gray BRAM port-A write for that pixel; must be ≥ 1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one frame; sampled only in IDLE
- valid_in  out  1  to data path `valid_in`; high exactly while read addresses are issued
- addr0_bram_read  out  ADRR_WIDTH_BRAM  RGB BRAM port-A read address
- addr0_bram_write  out  ADRR_WIDTH_BRAM  gray BRAM port-A write address
- write_strobe  out  1  delayed copy of `valid_in`; high on the cycle the gray write occurs (monitor/debug)
- busy  out  1  high from the cycle after `start` is accepted until `done`
- done  out  1  one-cycle pulse when the last gray pixel is written
- frame_count  out  16  number of completed frames, wraps modulo 2^16

## Operation
- N = IMAGE_HEIGHT*IMAGE_WIDTH; pixel index is linear, row-major, 0..N-1.
- FSM states:
  - IDLE: `start`=1 → READ.
  - READ: `valid_in`=1; `addr0_bram_read` = read counter, incremented each cycle; after index N-1 is issued → DRAIN.
  - DRAIN: `valid_in`=0; when the last delayed strobe (index N-1) has been emitted → DONE.
  - DONE: `done`=1 for one cycle, `frame_count`++ → IDLE.
- Delay line: {`valid_in`, read address} is delayed PIPE_LATENCY cycles to produce {`write_strobe`, `addr0_bram_write`}. Write address therefore equals the pixel index whose gray result is being written.
- `addr0_bram_read` holds its last value outside READ. `addr0_bram_write` holds its last delayed value when `write_strobe`=0.
- `start` in READ/DRAIN/DONE is ignored (not queued). `start` held high re-launches a frame on the first IDLE cycle after DONE.
- Read counter restarts at 0 each frame; no wrap within a frame.

## Timing
- Reset values: state IDLE, `valid_in`=0, both addresses 0, `write_strobe`=0, `busy`=0, `done`=0, `frame_count`=0, delay line cleared.
- `rst` mid-frame: next cycle all of the above; pending delayed strobes are discarded (no further writes).
- `start` seen high at edge of cycle 0 → cycle 1: `valid_in`=1, `busy`=1, read addr 0.
- Cycles 1..N: read addresses 0..N-1; cycle N+1: `valid_in`=0.
- Cycles 1+L..N+L (L = PIPE_LATENCY): `write_strobe`=1, write addresses 0..N-1.
- Cycle N+L+1: `done`=1, `busy`=1; cycle N+L+2: `busy`=0, `frame_count` updated, IDLE.
- All outputs registered; no combinational path from `start` to any output.

## Structure
- Shared package: state enumeration (IDLE, READ, DRAIN, DONE), localparam N and counter widths, frame-count width 16.
- One sub-module: `addr_delay_line` (parameterised depth PIPE_LATENCY, width ADRR_WIDTH_BRAM+1, synchronous-reset shift register) carrying {valid, address}.
- FSM, read counter, frame counter live in the top.

## Test plan
- Reset then single `start` pulse (defaults, N=25, L=3) → `valid_in` high cycles 1–25 with addr 0..24; `write_strobe` high cycles 4–28 with addr 0..24; `done` at cycle 29; `frame_count`=1.
- `start` pulsed at cycles 5 and 20 during a frame → ignored; exactly 25 writes, one `done`.
- `start` held high permanently → back-to-back frames, each `done` 30 cycles apart; `frame_count` 1,2,3 after three frames.
- `rst` asserted at cycle 12 of a frame → next cycle all outputs at reset values, no `write_strobe` afterward, `frame_count` stays 0.
- PIPE_LATENCY=1, IMAGE 8×8, ADRR_WIDTH_BRAM=6 → reads addr 0..63 cycles 1–64, writes 0..63 cycles 2–65, `done` cycle 66.
- Integrated with the data path and reference gray model: 5×5 RGB image → gray BRAM contents match model for all 25 addresses.
